// File: rtl/game_flow_pkg.sv
// Shared types and helpers for the frame-level game flow scheduler.
// State encoding is visible on gameState, so values are fixed.
package game_flow_pkg;

  localparam int P_ROCKETS = 2;
  localparam int A_ROCKETS = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PLAY = 3'd1,
    HIT  = 3'd2,
    OVER = 3'd3,
    WIN  = 3'd4
  } game_state_t;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/collision_sticky_latch.sv
// Sticky capture of per-pixel events plus the once-per-frame commit pulse.
// On commit the held bits become the pulse and the same cycle's events reload.
module collision_sticky_latch #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         capture,
  input  logic         commit,
  input  logic         clear,
  input  logic [W-1:0] events,
  output logic [W-1:0] held,
  output logic [W-1:0] pulse
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      held  <= '0;
      pulse <= '0;
    end else if (clear) begin
      held  <= '0;
      pulse <= '0;
    end else begin
      pulse <= commit ? held : '0;
      if (commit)
        held <= events;
      else if (capture)
        held <= held | events;
    end
  end

endmodule

// File: rtl/game_flow_scheduler.sv
// Frame-level game sequencer: commits collision stickies once per frame,
// runs the play/hit/over/win state machine and owns the lives counter.
module game_flow_scheduler
  import game_flow_pkg::*;
#(
  parameter int INIT_LIVES        = 3,
  parameter int HIT_FREEZE_FRAMES = 60,
  parameter int POINTS_PER_ALIEN  = 10
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic                 startGame,
  input  logic [P_ROCKETS-1:0] alienHit,
  input  logic                 playerHitByAlienPulse,
  input  logic [A_ROCKETS-1:0] playerHitByRocket,
  input  logic [P_ROCKETS-1:0] p_rocketsCollision,
  input  logic [A_ROCKETS-1:0] a_rocketsCollision,
  input  logic                 aliensReachedBorder,
  input  logic                 allAliensDead,
  output logic [P_ROCKETS-1:0] p_rocketKill,
  output logic [A_ROCKETS-1:0] a_rocketKill,
  output logic [P_ROCKETS-1:0] alienKill,
  output logic [7:0]           scoreAdd,
  output logic                 scoreValid,
  output logic [1:0]           lives,
  output logic [2:0]           gameState,
  output logic                 freeze
);

  localparam logic [1:0] LIVES_LOAD = 2'(INIT_LIVES);
  localparam logic [7:0] HIT_LOAD   = 8'(HIT_FREEZE_FRAMES);
  localparam logic [9:0] PTS        = 10'(POINTS_PER_ALIEN);

  game_state_t state;
  logic [7:0]  cnt;
  logic        border_s;
  logic        phit_s;

  logic                 play;
  logic                 commit;
  logic                 clear;
  logic                 phit_now;
  logic [9:0]           pts;
  logic [7:0]           score_sat;
  logic [P_ROCKETS-1:0] alien_held;
  logic [P_ROCKETS-1:0] p_held_unused;
  logic [A_ROCKETS-1:0] a_held_unused;

  assign play     = (state == PLAY);
  assign commit   = play && startOfFrame;
  assign phit_now = playerHitByAlienPulse || (|playerHitByRocket);
  assign clear    = ((state == IDLE || state == OVER || state == WIN)
                     && startGame)
                 || (state == HIT && startOfFrame && cnt <= 8'd1);

  assign pts       = 10'(popcount(8'(alien_held))) * PTS;
  assign score_sat = (pts > 10'd255) ? 8'hff : pts[7:0];
  assign gameState = state;

  collision_sticky_latch #(.W(P_ROCKETS)) u_alien (
    .clk     (clk),
    .resetN  (resetN),
    .capture (play),
    .commit  (commit),
    .clear   (clear),
    .events  (alienHit),
    .held    (alien_held),
    .pulse   (alienKill)
  );

  // A player rocket dies on a rocket-rocket hit or when it kills an alien.
  collision_sticky_latch #(.W(P_ROCKETS)) u_prkt (
    .clk     (clk),
    .resetN  (resetN),
    .capture (play),
    .commit  (commit),
    .clear   (clear),
    .events  (p_rocketsCollision | alienHit),
    .held    (p_held_unused),
    .pulse   (p_rocketKill)
  );

  collision_sticky_latch #(.W(A_ROCKETS)) u_arkt (
    .clk     (clk),
    .resetN  (resetN),
    .capture (play),
    .commit  (commit),
    .clear   (clear),
    .events  (a_rocketsCollision | playerHitByRocket),
    .held    (a_held_unused),
    .pulse   (a_rocketKill)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      lives      <= LIVES_LOAD;
      freeze     <= 1'b0;
      cnt        <= '0;
      border_s   <= 1'b0;
      phit_s     <= 1'b0;
      scoreAdd   <= '0;
      scoreValid <= 1'b0;
    end else begin
      scoreAdd   <= '0;
      scoreValid <= 1'b0;
      unique case (state)
        IDLE, OVER, WIN: begin
          freeze <= 1'b1;
          if (startGame) begin
            state    <= PLAY;
            lives    <= LIVES_LOAD;
            freeze   <= 1'b0;
            border_s <= 1'b0;
            phit_s   <= 1'b0;
          end
        end
        PLAY: begin
          if (startOfFrame) begin
            border_s   <= aliensReachedBorder;
            phit_s     <= phit_now;
            scoreAdd   <= score_sat;
            scoreValid <= (score_sat != 8'd0);
            if (border_s) begin
              state  <= OVER;
              lives  <= 2'd0;
              freeze <= 1'b1;
            end else if (phit_s) begin
              freeze <= 1'b1;
              if (lives <= 2'd1) begin
                lives <= 2'd0;
                state <= OVER;
              end else begin
                lives <= lives - 2'd1;
                state <= HIT;
                cnt   <= HIT_LOAD;
              end
            end else if (allAliensDead) begin
              state  <= WIN;
              freeze <= 1'b1;
            end
          end else begin
            border_s <= border_s | aliensReachedBorder;
            phit_s   <= phit_s | phit_now;
          end
        end
        HIT: begin
          freeze <= 1'b1;
          if (startOfFrame) begin
            if (cnt <= 8'd1) begin
              state    <= PLAY;
              freeze   <= 1'b0;
              border_s <= 1'b0;
              phit_s   <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          freeze <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_scheduler.sv
// Directed bench for game_flow_scheduler with a queue of expected commits.
// Each frame commit pops one expectation (empty queue means no pulses).
module tb_game_flow_scheduler;

  typedef struct packed {
    logic [1:0] pk;
    logic [2:0] ak;
    logic [1:0] al;
    logic [7:0] sa;
    logic       sv;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       startOfFrame;
  logic       startGame;
  logic [1:0] alienHit;
  logic       playerHitByAlienPulse;
  logic [2:0] playerHitByRocket;
  logic [1:0] p_rocketsCollision;
  logic [2:0] a_rocketsCollision;
  logic       aliensReachedBorder;
  logic       allAliensDead;
  logic [1:0] p_rocketKill;
  logic [2:0] a_rocketKill;
  logic [1:0] alienKill;
  logic [7:0] scoreAdd;
  logic       scoreValid;
  logic [1:0] lives;
  logic [2:0] gameState;
  logic       freeze;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  game_flow_scheduler dut (
    .clk                   (clk),
    .resetN                (resetN),
    .startOfFrame          (startOfFrame),
    .startGame             (startGame),
    .alienHit              (alienHit),
    .playerHitByAlienPulse (playerHitByAlienPulse),
    .playerHitByRocket     (playerHitByRocket),
    .p_rocketsCollision    (p_rocketsCollision),
    .a_rocketsCollision    (a_rocketsCollision),
    .aliensReachedBorder   (aliensReachedBorder),
    .allAliensDead         (allAliensDead),
    .p_rocketKill          (p_rocketKill),
    .a_rocketKill          (a_rocketKill),
    .alienKill             (alienKill),
    .scoreAdd              (scoreAdd),
    .scoreValid            (scoreValid),
    .lives                 (lives),
    .gameState             (gameState),
    .freeze                (freeze)
  );

  function automatic exp_t mk(input logic [1:0] pk,
                              input logic [2:0] ak,
                              input logic [1:0] al);
    exp_t e;
    int   p;
    p    = $countones(al) * 10;
    e.pk = pk;
    e.ak = ak;
    e.al = al;
    e.sa = (p > 255) ? 8'd255 : 8'(p);
    e.sv = (p != 0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sof_cycle(input string tag);
    exp_t e;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    e = (q.size() > 0) ? q.pop_front() : '0;
    chk({tag, "_pk"}, 32'(p_rocketKill), 32'(e.pk));
    chk({tag, "_ak"}, 32'(a_rocketKill), 32'(e.ak));
    chk({tag, "_al"}, 32'(alienKill), 32'(e.al));
    chk({tag, "_sa"}, 32'(scoreAdd), 32'(e.sa));
    chk({tag, "_sv"}, 32'(scoreValid), 32'(e.sv));
  endtask

  task automatic start_game();
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
  endtask

  initial begin
    resetN                = 1'b0;
    startOfFrame          = 1'b0;
    startGame             = 1'b0;
    alienHit              = '0;
    playerHitByAlienPulse = 1'b0;
    playerHitByRocket     = '0;
    p_rocketsCollision    = '0;
    a_rocketsCollision    = '0;
    aliensReachedBorder   = 1'b0;
    allAliensDead         = 1'b0;
    repeat (2) tick();

    chk("rst_lives", 32'(lives), 32'd3);
    chk("rst_state", 32'(gameState), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_pulses",
        32'({p_rocketKill, a_rocketKill, alienKill, scoreAdd, scoreValid}),
        32'd0);
    resetN = 1'b1;
    tick();
    chk("idle_freeze", 32'(freeze), 32'd1);

    // start and idle frames
    start_game();
    chk("start_state", 32'(gameState), 32'd1);
    chk("start_lives", 32'(lives), 32'd3);
    chk("start_freeze", 32'(freeze), 32'd0);
    repeat (3) sof_cycle("quiet");

    // single alien kill held for several cycles
    alienHit = 2'b01;
    repeat (5) tick();
    alienHit = 2'b00;
    q.push_back(mk(2'b01, 3'b000, 2'b01));
    sof_cycle("kill1");
    sof_cycle("kill1_after");

    // events on the commit cycle land one frame later
    p_rocketsCollision = 2'b10;
    a_rocketsCollision = 3'b100;
    sof_cycle("same_cycle");
    p_rocketsCollision = 2'b00;
    a_rocketsCollision = 3'b000;
    q.push_back(mk(2'b10, 3'b100, 2'b00));
    sof_cycle("next_frame");

    // player hit by alien rocket 0
    playerHitByRocket = 3'b001;
    tick();
    playerHitByRocket = 3'b000;
    q.push_back(mk(2'b00, 3'b001, 2'b00));
    sof_cycle("hit1");
    chk("hit1_lives", 32'(lives), 32'd2);
    chk("hit1_state", 32'(gameState), 32'd2);
    chk("hit1_freeze", 32'(freeze), 32'd1);
    alienHit  = 2'b11;
    startGame = 1'b1;
    repeat (3) tick();
    startGame = 1'b0;
    alienHit  = 2'b00;
    chk("hit_start_ignored", 32'(gameState), 32'd2);
    for (int i = 0; i < 59; i++) sof_cycle("frozen");
    chk("frozen_state", 32'(gameState), 32'd2);
    chk("frozen_freeze", 32'(freeze), 32'd1);
    sof_cycle("unfreeze");
    chk("unfreeze_state", 32'(gameState), 32'd1);
    chk("unfreeze_freeze", 32'(freeze), 32'd0);
    sof_cycle("post_hit");

    // second and third hits drain lives to zero
    playerHitByAlienPulse = 1'b1;
    tick();
    playerHitByAlienPulse = 1'b0;
    sof_cycle("hit2");
    chk("hit2_lives", 32'(lives), 32'd1);
    chk("hit2_state", 32'(gameState), 32'd2);
    repeat (60) sof_cycle("frozen2");
    chk("hit2_back", 32'(gameState), 32'd1);
    playerHitByRocket = 3'b100;
    tick();
    playerHitByRocket = 3'b000;
    q.push_back(mk(2'b00, 3'b100, 2'b00));
    sof_cycle("hit3");
    chk("hit3_lives", 32'(lives), 32'd0);
    chk("hit3_state", 32'(gameState), 32'd3);
    chk("hit3_freeze", 32'(freeze), 32'd1);
    playerHitByAlienPulse = 1'b1;
    tick();
    playerHitByAlienPulse = 1'b0;
    sof_cycle("over_quiet");
    chk("over_no_underflow", 32'(lives), 32'd0);
    start_game();
    chk("restart_state", 32'(gameState), 32'd1);
    chk("restart_lives", 32'(lives), 32'd3);

    // border beats all-dead; kill still paid out
    aliensReachedBorder = 1'b1;
    alienHit            = 2'b10;
    allAliensDead       = 1'b1;
    tick();
    aliensReachedBorder = 1'b0;
    alienHit            = 2'b00;
    q.push_back(mk(2'b10, 3'b000, 2'b10));
    sof_cycle("border");
    chk("border_state", 32'(gameState), 32'd3);
    chk("border_lives", 32'(lives), 32'd0);
    start_game();
    alienHit = 2'b11;
    tick();
    alienHit = 2'b00;
    q.push_back(mk(2'b11, 3'b000, 2'b11));
    sof_cycle("win");
    chk("win_state", 32'(gameState), 32'd4);
    chk("win_lives", 32'(lives), 32'd3);
    chk("win_freeze", 32'(freeze), 32'd1);
    allAliensDead = 1'b0;
    sof_cycle("win_quiet");

    // reset mid-frame drops pending stickies
    start_game();
    alienHit = 2'b01;
    repeat (3) tick();
    alienHit = 2'b00;
    resetN   = 1'b0;
    #1;
    chk("midrst_state", 32'(gameState), 32'd0);
    chk("midrst_lives", 32'(lives), 32'd3);
    tick();
    resetN = 1'b1;
    tick();
    start_game();
    chk("midrst_play", 32'(gameState), 32'd1);
    sof_cycle("midrst_discard");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
